// File: rtl/axis_pkt_gen_pkg.sv
// ============================================================================
// Module   : axis_pkt_gen_pkg
// Brief    : Shared state encoding and packet-content helper functions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_pkt_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MAX_LANES = 64;

  function automatic logic [7:0] pkt_byte(input logic [7:0] seed,
                                          input int unsigned p,
                                          input int unsigned k);
    return seed + 8'(p + k);
  endfunction

  // Lengths past the MTU fold back into 1..mtu rather than saturating.
  function automatic int unsigned pkt_blen(input int unsigned first,
                                           input int unsigned step,
                                           input int unsigned p,
                                           input int unsigned mtu);
    int unsigned raw;
    raw = first + p * step;
    return (raw > mtu) ? (((raw - 1) % mtu) + 1) : raw;
  endfunction

  function automatic logic [MAX_LANES-1:0] blen_to_tkeep(input int unsigned r,
                                                         input int unsigned data_bytes);
    int unsigned n;
    n = (r == 0) ? data_bytes : r;
    return (n >= MAX_LANES) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_pkt_gen_if.sv
// ============================================================================
// Module   : AXIS_int
// Brief    : AXI-Stream bundle with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface AXIS_int #(
  parameter int DATA_BYTES = 4
);
  logic [DATA_BYTES*8-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport Master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport Slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/axis_pkt_gen_beat.sv
// ============================================================================
// Module   : axis_pkt_gen_beat
// Brief    : Forms one beat (tdata/tkeep/tlast) of a generated packet.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_pkt_gen_beat
  import axis_pkt_gen_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int PKT_W      = 5,
  parameter int BLEN_W     = 9
) (
  input  logic [7:0]              i_seed,
  input  logic [PKT_W-1:0]        i_pkt,
  input  logic [BLEN_W-1:0]       i_beat,
  input  logic [BLEN_W-1:0]       i_blen,
  output logic [DATA_BYTES*8-1:0] o_tdata,
  output logic [DATA_BYTES-1:0]   o_tkeep,
  output logic                    o_tlast
);

  logic [31:0] w_base;

  assign w_base  = 32'(i_beat) * 32'(DATA_BYTES);
  assign o_tlast = (w_base + 32'(DATA_BYTES)) >= 32'(i_blen);
  assign o_tkeep = o_tlast
                 ? DATA_BYTES'(blen_to_tkeep(32'(i_blen) % 32'(DATA_BYTES), 32'(DATA_BYTES)))
                 : '1;

  for (genvar l = 0; l < DATA_BYTES; l++) begin : g_lane
    assign o_tdata[8*l +: 8] = ((w_base + 32'(l)) < 32'(i_blen))
                             ? pkt_byte(i_seed, 32'(i_pkt), w_base + 32'(l))
                             : 8'h00;
  end

endmodule

`default_nettype wire

// File: rtl/axis_pkt_gen.sv
// ============================================================================
// Module   : axis_pkt_gen
// Brief    : Programmable AXIS packet-burst source with a snoop buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int MTU_BYTES                  = 256,
  parameter int NUM_PACKETS_BEING_SENT     = 16,
  parameter int NUM_PACKETS_BEING_SENT_LOG = $clog2(NUM_PACKETS_BEING_SENT + 1),
  parameter int BLEN_W                     = $clog2(MTU_BYTES + 1)
) (
  input  logic                                  clk,
  input  logic                                  sresetn,
  AXIS_int.Master                               axis_out,
  input  logic                                  start,
  input  logic [NUM_PACKETS_BEING_SENT_LOG-1:0] cfg_num_pkts,
  input  logic [BLEN_W-1:0]                     cfg_first_blen,
  input  logic [BLEN_W-1:0]                     cfg_blen_step,
  input  logic [7:0]                            cfg_gap,
  input  logic [7:0]                            cfg_seed,
  output logic                                  busy,
  output logic                                  done,
  output logic [NUM_PACKETS_BEING_SENT_LOG-1:0] num_tx_pkts,
  output logic [MTU_BYTES*8-1:0]                expected_pkts  [NUM_PACKETS_BEING_SENT],
  output logic [BLEN_W-1:0]                     expected_blens [NUM_PACKETS_BEING_SENT]
);

  localparam int DATA_BYTES = $bits(axis_out.tkeep);
  localparam int PKT_W      = NUM_PACKETS_BEING_SENT_LOG;
  localparam int IDX_W      = (NUM_PACKETS_BEING_SENT > 1) ? $clog2(NUM_PACKETS_BEING_SENT) : 1;

  state_t                  r_state;
  logic [7:0]              r_seed, r_gap, r_gap_cnt;
  logic [BLEN_W-1:0]       r_first, r_step, r_blen, r_beat;
  logic [PKT_W-1:0]        r_num, r_pkt, r_ntx;
  logic                    r_tvalid, r_tlast, r_busy, r_done;
  logic [DATA_BYTES*8-1:0] r_tdata;
  logic [DATA_BYTES-1:0]   r_tkeep;
  logic [MTU_BYTES*8-1:0]  r_exp_pkts  [NUM_PACKETS_BEING_SENT];
  logic [BLEN_W-1:0]       r_exp_blens [NUM_PACKETS_BEING_SENT];

  logic                    w_hs, w_roll, w_last_pkt;
  logic [PKT_W-1:0]        w_pkt_inc, w_num, w_b_pkt;
  logic [BLEN_W-1:0]       w_first, w_blen0, w_blen_nxt, w_b_beat, w_b_blen;
  logic [IDX_W-1:0]        w_widx;
  logic [DATA_BYTES*8-1:0] w_b_tdata;
  logic [DATA_BYTES-1:0]   w_b_tkeep;
  logic                    w_b_tlast;
  logic [MTU_BYTES*8-1:0]  w_img;

  assign w_hs       = r_tvalid & axis_out.tready;
  assign w_pkt_inc  = r_pkt + 1'b1;
  assign w_last_pkt = (w_pkt_inc == r_num);
  assign w_widx     = IDX_W'(r_pkt);
  assign w_num      = (cfg_num_pkts > PKT_W'(NUM_PACKETS_BEING_SENT))
                    ? PKT_W'(NUM_PACKETS_BEING_SENT) : cfg_num_pkts;
  assign w_first    = (cfg_first_blen == '0) ? BLEN_W'(1) : cfg_first_blen;
  assign w_blen0    = BLEN_W'(pkt_blen(32'(w_first), 32'd0, 32'd0, 32'(MTU_BYTES)));
  assign w_blen_nxt = BLEN_W'(pkt_blen(32'(r_first), 32'(r_step), 32'(w_pkt_inc), 32'(MTU_BYTES)));

  // The beat former always looks one beat ahead of what is on the bus; a
  // back-to-back packet (gap 0) needs the next packet's beat 0 directly.
  assign w_roll   = (r_state == SEND) && r_tlast;
  assign w_b_pkt  = w_roll ? w_pkt_inc : r_pkt;
  assign w_b_blen = w_roll ? w_blen_nxt : r_blen;
  assign w_b_beat = ((r_state == SEND) && !r_tlast) ? r_beat + 1'b1 : '0;

  axis_pkt_gen_beat #(
    .DATA_BYTES (DATA_BYTES),
    .PKT_W      (PKT_W),
    .BLEN_W     (BLEN_W)
  ) u_beat (
    .i_seed  (r_seed),
    .i_pkt   (w_b_pkt),
    .i_beat  (w_b_beat),
    .i_blen  (w_b_blen),
    .o_tdata (w_b_tdata),
    .o_tkeep (w_b_tkeep),
    .o_tlast (w_b_tlast)
  );

  for (genvar k = 0; k < MTU_BYTES; k++) begin : g_img
    assign w_img[8*k +: 8] = (32'(k) < 32'(r_blen)) ? pkt_byte(r_seed, 32'(r_pkt), 32'(k)) : 8'h00;
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      r_state   <= IDLE;
      r_seed    <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_first   <= '0;
      r_step    <= '0;
      r_blen    <= '0;
      r_beat    <= '0;
      r_num     <= '0;
      r_pkt     <= '0;
      r_ntx     <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tdata   <= '0;
      r_tkeep   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      for (int i = 0; i < NUM_PACKETS_BEING_SENT; i++) begin
        r_exp_pkts[i]  <= '0;
        r_exp_blens[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_seed    <= cfg_seed;
            r_first   <= w_first;
            r_step    <= cfg_blen_step;
            r_gap     <= cfg_gap;
            r_num     <= w_num;
            r_pkt     <= '0;
            r_beat    <= '0;
            r_blen    <= w_blen0;
            r_gap_cnt <= '0;
            r_ntx     <= '0;
            for (int i = 0; i < NUM_PACKETS_BEING_SENT; i++) begin
              r_exp_pkts[i]  <= '0;
              r_exp_blens[i] <= '0;
            end
            if (w_num == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              // A zero-length countdown gives one cycle to load beat 0.
              r_state <= GAP;
              r_busy  <= 1'b1;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == '0) begin
            r_state  <= SEND;
            r_tvalid <= 1'b1;
            r_tdata  <= w_b_tdata;
            r_tkeep  <= w_b_tkeep;
            r_tlast  <= w_b_tlast;
            r_beat   <= w_b_beat;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        SEND: begin
          if (w_hs) begin
            if (r_tlast) begin
              r_exp_pkts[w_widx]  <= w_img;
              r_exp_blens[w_widx] <= r_blen;
              r_ntx               <= r_ntx + 1'b1;
              if (w_last_pkt) begin
                r_state  <= DONE;
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
                r_tdata  <= '0;
                r_tkeep  <= '0;
              end else if (r_gap != '0) begin
                r_state   <= GAP;
                r_gap_cnt <= r_gap - 8'd1;
                r_pkt     <= w_pkt_inc;
                r_blen    <= w_blen_nxt;
                r_tvalid  <= 1'b0;
                r_tlast   <= 1'b0;
                r_tdata   <= '0;
                r_tkeep   <= '0;
              end else begin
                r_pkt   <= w_pkt_inc;
                r_blen  <= w_blen_nxt;
                r_beat  <= '0;
                r_tdata <= w_b_tdata;
                r_tkeep <= w_b_tkeep;
                r_tlast <= w_b_tlast;
              end
            end else begin
              r_beat  <= w_b_beat;
              r_tdata <= w_b_tdata;
              r_tkeep <= w_b_tkeep;
              r_tlast <= w_b_tlast;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign axis_out.tvalid = r_tvalid;
  assign axis_out.tdata  = r_tdata;
  assign axis_out.tkeep  = r_tkeep;
  assign axis_out.tlast  = r_tlast;
  assign busy            = r_busy;
  assign done            = r_done;
  assign num_tx_pkts     = r_ntx;
  assign expected_pkts   = r_exp_pkts;
  assign expected_blens  = r_exp_blens;

endmodule

`default_nettype wire

// File: doc/axis_pkt_gen.md
Name: axis_pkt_gen

Overview:
- Synthesizable stimulus source that sits directly upstream of the per-port packet checker in the AXIS array benches.
- Emits a programmed burst of packets on one AXIS master port.
- Every payload is deterministic, built from incrementing bytes.
- Records each transmitted packet in a snoop buffer (packet image, byte length, count). The downstream checker consumes this buffer as its expected-packet set.
- One instance per port; each port has its own configuration.

Parameters:
MTU_BYTES, 256, largest packet in bytes; sets snoop entry width.
NUM_PACKETS_BEING_SENT, 16, snoop buffer depth; upper bound on packets per burst.
NUM_PACKETS_BEING_SENT_LOG, $clog2(NUM_PACKETS_BEING_SENT+1), width of packet counts.
BLEN_W, $clog2(MTU_BYTES+1), width of byte lengths.

Ports:
clk  in  1  single clock; all logic on its rising edge.
sresetn  in  1  asynchronous, active-low reset; deassertion synchronised to clk by the instantiating bench.
axis_out  AXIS_int.Master  DATA_BYTES from interface  generated packet stream; uses tdata, tkeep, tlast, tvalid, tready.
start  in  1  single-cycle pulse; launches a burst.
cfg_num_pkts  in  NUM_PACKETS_BEING_SENT_LOG  packets in the burst; 0..NUM_PACKETS_BEING_SENT.
cfg_first_blen  in  BLEN_W  byte length of packet 0; 1..MTU_BYTES.
cfg_blen_step  in  BLEN_W  length increment per packet.
cfg_gap  in  8  idle cycles between packets.
cfg_seed  in  8  first byte value of packet 0.
busy  out  1  high from accepted start until done.
done  out  1  one-cycle pulse at burst end.
num_tx_pkts  out  NUM_PACKETS_BEING_SENT_LOG  packets fully transmitted in this burst.
expected_pkts  out  [MTU_BYTES*8-1:0] x NUM_PACKETS_BEING_SENT  snoop images; byte k at bits [8k+:8].
expected_blens  out  BLEN_W x NUM_PACKETS_BEING_SENT  snoop byte lengths.

Behaviour:
- Reset (async assert):
  - tvalid=0, tlast=0, tdata=0, tkeep=0.
  - busy=0, done=0, num_tx_pkts=0.
  - All snoop entries 0. State IDLE.
  - Reset mid-packet abandons the packet immediately; no completion is recorded.
- Configuration: sampled into registers on the accepted start. Changes during a burst are ignored.
- Packet contents:
  - byte k of packet p = (cfg_seed + p + k) mod 256.
  - blen_p = cfg_first_blen + p*cfg_blen_step, computed at BLEN_W+NUM_PACKETS_BEING_SENT_LOG bits.
  - If blen_p > MTU_BYTES, use ((blen_p-1) mod MTU_BYTES)+1. Result is always 1..MTU_BYTES.
- Beat format:
  - Beats = ceil(blen_p/DATA_BYTES). Byte k sits in beat k/DATA_BYTES, lane k%DATA_BYTES (lane 0 = tdata[7:0]).
  - tkeep is all ones except on the last beat, which is (1<<r)-1 with r=blen_p%DATA_BYTES; r=0 gives all ones.
  - Unused lanes carry 0. tlast=1 only on the last beat.
- AXIS rules:
  - Once tvalid is asserted, tdata/tkeep/tlast are held stable and tvalid stays high until tready.
  - tvalid never depends combinationally on tready.
  - Next beat is presented the cycle after the handshake (full throughput under constant tready).
- State machine:
  - IDLE: start with cfg_num_pkts>0 -> SEND. busy=1; num_tx_pkts and all snoop entries are cleared in the same cycle.
  - IDLE: start with cfg_num_pkts=0 -> DONE; no beats are sent.
  - SEND: on the tlast handshake:
    - write expected_pkts[p] and expected_blens[p]; num_tx_pkts increments, visible the next cycle.
    - last packet -> DONE.
    - otherwise cfg_gap>0 -> GAP; cfg_gap=0 -> SEND with no bubble.
  - GAP: cfg_gap-cycle countdown with tvalid=0 -> SEND.
  - DONE: done=1 for one cycle, busy falls the same cycle -> IDLE.
- Boundaries:
  - start while busy is ignored.
  - cfg_num_pkts > NUM_PACKETS_BEING_SENT is clamped to NUM_PACKETS_BEING_SENT.
  - cfg_first_blen=0 is treated as 1.
  - Stalls of any length are allowed.
- Snoop entry: each image is zero above blen_p and updates atomically on the packet's tlast handshake.

Decomposition:
- Shared package axis_pkt_gen_pkg:
  - state enum (IDLE, SEND, GAP, DONE).
  - function pkt_byte(seed,p,k).
  - function pkt_blen(first,step,p,mtu).
  - function blen_to_tkeep(r, DATA_BYTES).
  - The checker imports the same functions so it can independently predict data.
- One natural sub-module, axis_pkt_gen_beat: given seed, packet index, beat index and blen, it combinationally forms tdata/tkeep/tlast.
- The top holds the FSM, counters and snoop buffer.

Test Plan:
- DATA_BYTES=4, seed=0x10, num=1, blen=6, gap=0, tready=1:
  - 2 beats: tdata 0x13121110 then 0x00001514, tkeep 0xF then 0x3, tlast on beat 2.
  - done 1 cycle after the last handshake; expected_blens[0]=6.
- num=3, first=4, step=4, gap=2:
  - lengths 4/8/12.
  - exactly 2 idle cycles between tlast and next tvalid.
  - num_tx_pkts steps 1,2,3.
  - packet 1 byte 0 = seed+1.
- Random tready (50%), num=16, first=1, step=37, MTU=256:
  - output is stable while stalled; packet 7 length 260 wraps to 4.
  - checker reports zero mismatches; all 16 snoop entries match.
- num=0 start: no tvalid; done pulses the cycle after start; busy never high beyond that cycle.
- sresetn low mid-packet 2 of 4: tvalid drops at once; num_tx_pkts=0 after reset; a new start sends a clean burst.
- start pulsed again while busy: ignored; burst count and contents unchanged.
